rr_scheduler_w1024: RTL and testbench
=====================================

RR_SCHEDULER_W1024 -- requirements
Module: rr_scheduler_w1024

Interface
REQ-001 SHALL have parameter N, default 1024, number of requesters.
REQ-002 SHALL have parameter LOGN, default 10, width of index and pointer.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  N  request vector; bit i = requester i pending.
REQ-006 SHALL have port cfg_ptr_wr  input  1  write strobe for the priority pointer.
REQ-007 SHALL have port cfg_ptr  input  LOGN  new priority pointer value.
REQ-008 SHALL have port grant_valid  output  1  grant offered.
REQ-009 SHALL have port grant_ready  input  1  consumer accepts grant.
REQ-010 SHALL have port grant_idx  output  LOGN  granted requester index.
REQ-011 SHALL have port ptr  output  LOGN  current priority pointer (highest-priority index).
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ARB and GRANT.
REQ-014 IDLE: if any req bit is 1, SHALL go to ARB next cycle; otherwise SHALL stay in IDLE.
REQ-015 IDLE->ARB: SHALL register req into a snapshot; later req changes SHALL NOT affect the arbitration in progress.
REQ-016 ARB: SHALL build mask bit i = 1 when i < ptr (thermometer of ptr).
REQ-017 ARB: SHALL form hi = snapshot AND NOT mask.
REQ-018 ARB: SHALL pick the lowest set index of hi if hi is nonzero, else the lowest set index of snapshot.
REQ-019 ARB: SHALL register the pick into grant_idx and go to GRANT; fixed latency is 2 cycles from req sampled in IDLE to grant_valid=1.
REQ-020 GRANT: grant_valid SHALL be 1, and grant_idx SHALL stay stable until the handshake.
REQ-021 Handshake is grant_valid AND grant_ready; on it, SHALL set ptr to grant_idx+1 modulo N (1023 wraps to 0) and go to IDLE.
REQ-022 GRANT with grant_ready=0: SHALL hold GRANT indefinitely, even if the granted req bit deasserts.
REQ-023 grant_valid SHALL be 0 in IDLE and ARB; no combinational path from grant_ready to grant_valid.
REQ-024 cfg_ptr_wr SHALL be accepted in any state and load ptr with cfg_ptr next cycle.
REQ-025 cfg_ptr_wr in the same cycle as a handshake: the cfg write SHALL win over the REQ-021 ptr update; the handshake still completes.
REQ-026 cfg_ptr_wr during ARB: the ARB pick SHALL use the ptr value before the write; the new ptr applies from the next arbitration.
REQ-027 Snapshot all-zero cannot occur (ARB is entered only with a nonzero req); grant_idx from hi/req encode SHALL be exact for all N indices.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 After a handshake, SHALL spend at least one cycle in IDLE; maximum grant rate is one per 3 cycles.

Reset
REQ-030 rst_n=0 SHALL asynchronously set state=IDLE, grant_valid=0, grant_idx=0, ptr=0, busy=0 and snapshot=0.
REQ-031 Reset asserted in ARB or GRANT SHALL abort the grant with no handshake and no ptr update.
REQ-032 After rst_n deasserts, the first arbitration SHALL be evaluated no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 Reset, then req bits {5, 900} held, ready=1 -> grant 5 (cycle 2), ptr=6; next grant 900, ptr=901; next grant 5 (wrap).
REQ-034 cfg_ptr=1023, req bits {0, 1023} -> grant 1023, ptr=0; next grant 0, ptr=1.
REQ-035 Grant with ready=0 for 10 cycles while req toggles -> grant_valid=1 and grant_idx constant throughout; ptr unchanged until ready=1.
REQ-036 cfg_ptr_wr=1, cfg_ptr=100 in the same cycle as a handshake of idx 7 -> ptr=100, not 8.
REQ-037 rst_n pulsed low while in GRANT with idx 42 -> grant_valid drops immediately (asynchronous), ptr=0, busy=0.
REQ-038 All 1024 req bits set, ready=1, run 1024 grants -> indices 0..1023 each granted exactly once, in order.

Source files
------------

// File: rtl/rr_scheduler_w1024.sv
// Round-robin scheduler over N requesters with a programmable priority pointer.
// Snapshot in IDLE, pick in ARB, offer a valid/ready grant in GRANT.
module rr_scheduler_w1024 #(
    parameter int unsigned N    = 1024,
    parameter int unsigned LOGN = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            cfg_ptr_wr,
    input  logic [LOGN-1:0] cfg_ptr,
    output logic            grant_valid,
    input  logic            grant_ready,
    output logic [LOGN-1:0] grant_idx,
    output logic [LOGN-1:0] ptr,
    output logic            busy
);

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StGrant
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    snap_q, snap_d;
    logic [LOGN-1:0] grant_idx_q, grant_idx_d;
    logic [LOGN-1:0] ptr_q, ptr_d;

    logic [N-1:0]    mask;
    logic [N-1:0]    hi;
    logic            hi_any;
    logic [LOGN-1:0] hi_idx;
    logic [LOGN-1:0] snap_idx;
    logic [LOGN-1:0] pick;
    logic            handshake;
    logic [LOGN-1:0] ptr_inc;

    function automatic logic [LOGN-1:0] lowest_set(input logic [N-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = LOGN'(i);
            end
        end
        return r;
    endfunction

    // Thermometer mask: requesters below the pointer lose priority this round.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (LOGN'(i) < ptr_q);
        end
    end

    assign hi       = snap_q & ~mask;
    assign hi_any   = |hi;
    assign hi_idx   = lowest_set(hi);
    assign snap_idx = lowest_set(snap_q);
    assign pick     = hi_any ? hi_idx : snap_idx;

    assign handshake = (state_q == StGrant) && grant_ready;
    assign ptr_inc   = (grant_idx_q == LOGN'(N - 1)) ? '0 : grant_idx_q + LOGN'(1);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    snap_d  = req;
                    state_d = StArb;
                end
            end
            StArb: begin
                grant_idx_d = pick;
                state_d     = StGrant;
            end
            StGrant: begin
                if (handshake) begin
                    ptr_d   = ptr_inc;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A configuration write overrides the post-handshake pointer advance.
        if (cfg_ptr_wr) begin
            ptr_d = cfg_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            snap_q      <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant_valid = (state_q == StGrant);
    assign grant_idx   = grant_idx_q;
    assign ptr         = ptr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_rr_scheduler_w1024.sv
// Scoreboard bench for rr_scheduler_w1024: expected grants and pointers are queued
// as stimulus is applied and compared when the scheduler offers each grant.
module tb_rr_scheduler_w1024;

    localparam int N    = 1024;
    localparam int LOGN = 10;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic            cfg_ptr_wr;
    logic [LOGN-1:0] cfg_ptr;
    logic            grant_valid;
    logic            grant_ready;
    logic [LOGN-1:0] grant_idx;
    logic [LOGN-1:0] ptr;
    logic            busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [LOGN-1:0] exp_idx_q[$];
    logic [LOGN-1:0] exp_ptr_q[$];

    rr_scheduler_w1024 #(
        .N   (N),
        .LOGN(LOGN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .cfg_ptr_wr (cfg_ptr_wr),
        .cfg_ptr    (cfg_ptr),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .grant_idx  (grant_idx),
        .ptr        (ptr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge where a grant is offered.
    task automatic wait_grant(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (grant_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req         = '0;
        req[3]      = 1'b1;
        cfg_ptr_wr  = 1'b0;
        cfg_ptr     = '0;
        grant_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || ptr !== '0 || grant_idx !== '0) begin
            $display("FAIL reset_state: got gv=%b busy=%b ptr=%0d idx=%0d required 0 0 0 0",
                     grant_valid, busy, ptr, grant_idx);
        end else begin
            pass_cnt++;
        end
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_idle_after_release: got busy=%b required 0", busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        bit got;
        logic [LOGN-1:0] e, ep;
        req         = '0;
        req[5]      = 1'b1;
        req[900]    = 1'b1;
        grant_ready = 1'b1;
        exp_idx_q.push_back(10'd5);   exp_ptr_q.push_back(10'd6);
        exp_idx_q.push_back(10'd900); exp_ptr_q.push_back(10'd901);
        exp_idx_q.push_back(10'd5);   exp_ptr_q.push_back(10'd6);
        @(negedge clk);
        chk_cnt++;
        if (grant_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL latency_arb: got gv=%b busy=%b required gv=0 busy=1",
                     grant_valid, busy);
        end else begin
            pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++;
        if (grant_valid !== 1'b1) begin
            $display("FAIL latency_grant: got gv=%b required 1", grant_valid);
        end else begin
            pass_cnt++;
        end
        while (exp_idx_q.size() > 0) begin
            wait_grant(20, got);
            e  = exp_idx_q.pop_front();
            ep = exp_ptr_q.pop_front();
            chk_cnt++;
            if (!got || grant_idx !== e) begin
                $display("FAIL rotation_idx: got valid=%b idx=%0d required idx=%0d", got,
                         grant_idx, e);
            end else begin
                pass_cnt++;
            end
            if (exp_idx_q.size() == 0) req = '0;
            @(negedge clk);
            chk_cnt++;
            if (ptr !== ep || busy !== 1'b0) begin
                $display("FAIL rotation_ptr: got ptr=%0d busy=%b required ptr=%0d busy=0",
                         ptr, busy, ep);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        bit got;
        logic [LOGN-1:0] e, ep;
        cfg_ptr_wr = 1'b1;
        cfg_ptr    = 10'd1023;
        @(negedge clk);
        cfg_ptr_wr = 1'b0;
        chk_cnt++;
        if (ptr !== 10'd1023) begin
            $display("FAIL cfg_write: got ptr=%0d required 1023", ptr);
        end else begin
            pass_cnt++;
        end
        req         = '0;
        req[0]      = 1'b1;
        req[1023]   = 1'b1;
        grant_ready = 1'b1;
        exp_idx_q.push_back(10'd1023); exp_ptr_q.push_back(10'd0);
        exp_idx_q.push_back(10'd0);    exp_ptr_q.push_back(10'd1);
        while (exp_idx_q.size() > 0) begin
            @(negedge clk);
            wait_grant(20, got);
            e  = exp_idx_q.pop_front();
            ep = exp_ptr_q.pop_front();
            chk_cnt++;
            if (!got || grant_idx !== e) begin
                $display("FAIL wrap_idx: got valid=%b idx=%0d required idx=%0d", got,
                         grant_idx, e);
            end else begin
                pass_cnt++;
            end
            if (exp_idx_q.size() == 0) req = '0;
            @(negedge clk);
            chk_cnt++;
            if (ptr !== ep) begin
                $display("FAIL wrap_ptr: got ptr=%0d required %0d", ptr, ep);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_hold();
        bit got;
        logic [LOGN-1:0] e;
        grant_ready = 1'b0;
        req         = '0;
        req[300]    = 1'b1;
        exp_idx_q.push_back(10'd300);
        @(negedge clk);
        wait_grant(20, got);
        e = exp_idx_q.pop_front();
        chk_cnt++;
        if (!got || grant_idx !== e) begin
            $display("FAIL hold_idx: got valid=%b idx=%0d required idx=%0d", got, grant_idx, e);
        end else begin
            pass_cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            req = '0;
            req[$urandom_range(0, N - 1)] = 1'b1;
            req[300] = k[0];
            @(negedge clk);
            chk_cnt++;
            if (grant_valid !== 1'b1 || grant_idx !== e || ptr !== 10'd1) begin
                $display("FAIL hold_stable: got gv=%b idx=%0d ptr=%0d required gv=1 idx=%0d ptr=1",
                         grant_valid, grant_idx, ptr, e);
            end else begin
                pass_cnt++;
            end
        end
        grant_ready = 1'b1;
        req         = '0;
        @(negedge clk);
        chk_cnt++;
        if (ptr !== 10'd301 || busy !== 1'b0) begin
            $display("FAIL hold_release: got ptr=%0d busy=%b required ptr=301 busy=0", ptr, busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_cfg_collision();
        bit got;
        logic [LOGN-1:0] e;
        grant_ready = 1'b0;
        req         = '0;
        req[7]      = 1'b1;
        exp_idx_q.push_back(10'd7);
        @(negedge clk);
        wait_grant(20, got);
        e = exp_idx_q.pop_front();
        chk_cnt++;
        if (!got || grant_idx !== e) begin
            $display("FAIL collision_idx: got valid=%b idx=%0d required idx=%0d", got,
                     grant_idx, e);
        end else begin
            pass_cnt++;
        end
        grant_ready = 1'b1;
        cfg_ptr_wr  = 1'b1;
        cfg_ptr     = 10'd100;
        req         = '0;
        @(negedge clk);
        cfg_ptr_wr = 1'b0;
        chk_cnt++;
        if (ptr !== 10'd100 || busy !== 1'b0 || grant_valid !== 1'b0) begin
            $display("FAIL collision_ptr: got ptr=%0d busy=%b gv=%b required ptr=100 busy=0 gv=0",
                     ptr, busy, grant_valid);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_cfg_during_arb();
        bit got;
        logic [LOGN-1:0] e;
        grant_ready = 1'b1;
        req         = '0;
        req[50]     = 1'b1;
        req[200]    = 1'b1;
        exp_idx_q.push_back(10'd200);
        @(negedge clk);
        cfg_ptr_wr = 1'b1;
        cfg_ptr    = 10'd0;
        @(negedge clk);
        cfg_ptr_wr = 1'b0;
        wait_grant(20, got);
        e = exp_idx_q.pop_front();
        chk_cnt++;
        if (!got || grant_idx !== e) begin
            $display("FAIL arb_cfg_idx: got valid=%b idx=%0d required idx=%0d", got, grant_idx, e);
        end else begin
            pass_cnt++;
        end
        req = '0;
        @(negedge clk);
        chk_cnt++;
        if (ptr !== 10'd201) begin
            $display("FAIL arb_cfg_ptr: got ptr=%0d required 201", ptr);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset_in_grant();
        bit got;
        logic [LOGN-1:0] e;
        grant_ready = 1'b0;
        req         = '0;
        req[42]     = 1'b1;
        exp_idx_q.push_back(10'd42);
        @(negedge clk);
        wait_grant(20, got);
        e = exp_idx_q.pop_front();
        chk_cnt++;
        if (!got || grant_idx !== e) begin
            $display("FAIL rst_grant_idx: got valid=%b idx=%0d required idx=%0d", got,
                     grant_idx, e);
        end else begin
            pass_cnt++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || ptr !== '0 || grant_idx !== '0) begin
            $display("FAIL rst_async: got gv=%b busy=%b ptr=%0d idx=%0d required 0 0 0 0",
                     grant_valid, busy, ptr, grant_idx);
        end else begin
            pass_cnt++;
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || ptr !== '0) begin
            $display("FAIL rst_after: got busy=%b ptr=%0d required busy=0 ptr=0", busy, ptr);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_full_sweep();
        bit got;
        logic [LOGN-1:0] e, ep;
        int errs;
        errs        = 0;
        grant_ready = 1'b1;
        req         = '1;
        for (int i = 0; i < N; i++) begin
            exp_idx_q.push_back(LOGN'(i));
            exp_ptr_q.push_back(LOGN'((i + 1) % N));
        end
        while (exp_idx_q.size() > 0) begin
            @(negedge clk);
            wait_grant(10, got);
            e  = exp_idx_q.pop_front();
            ep = exp_ptr_q.pop_front();
            chk_cnt++;
            if (!got || grant_idx !== e) begin
                if (errs < 10) begin
                    $display("FAIL sweep_idx: got valid=%b idx=%0d required idx=%0d", got,
                             grant_idx, e);
                end
                errs++;
            end else begin
                pass_cnt++;
            end
            if (exp_idx_q.size() == 0) req = '0;
            @(negedge clk);
            chk_cnt++;
            if (ptr !== ep) begin
                if (errs < 10) begin
                    $display("FAIL sweep_ptr: got ptr=%0d required %0d", ptr, ep);
                end
                errs++;
            end else begin
                pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_hold();
        test_cfg_collision();
        test_cfg_during_arb();
        test_reset_in_grant();
        test_full_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
